// File: rtl/rs_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : rs_issue_queue_if
// Brief   : Dispatch, result-broadcast and FU issue bundle of the reservation
//           station; slave = the station, master = its environment.
// Rev     : 1.0
// ============================================================================
interface rs_issue_queue_if #(
    parameter int GPR_SIZE     = 32,
    parameter int ROB_IDX_SIZE = 5,
    parameter int FU_OP_SIZE   = 4
) ();
    logic                    in_disp_valid;
    logic                    in_disp_is_ls;
    logic [FU_OP_SIZE-1:0]   in_disp_fu_op;
    logic                    in_disp_a_ready;
    logic [GPR_SIZE-1:0]     in_disp_a_val;
    logic [ROB_IDX_SIZE-1:0] in_disp_a_tag;
    logic                    in_disp_b_ready;
    logic [GPR_SIZE-1:0]     in_disp_b_val;
    logic [ROB_IDX_SIZE-1:0] in_disp_b_tag;
    logic [ROB_IDX_SIZE-1:0] in_disp_dst_rob_index;
    logic                    in_disp_set_nzcv;
    logic [3:0]              in_disp_nzcv;
    logic [3:0]              in_disp_cond;
    logic                    in_fu_done;
    logic [ROB_IDX_SIZE-1:0] in_fu_dst_rob_index;
    logic [GPR_SIZE-1:0]     in_fu_value;
    logic                    in_fu_alu_ready;
    logic                    in_fu_ls_ready;
    logic                    in_flush;
    logic                    out_disp_ready;
    logic                    out_alu_start;
    logic [FU_OP_SIZE-1:0]   out_alu_fu_op;
    logic [GPR_SIZE-1:0]     out_alu_val_a;
    logic [GPR_SIZE-1:0]     out_alu_val_b;
    logic [ROB_IDX_SIZE-1:0] out_alu_dst_rob_index;
    logic                    out_alu_set_nzcv;
    logic [3:0]              out_alu_nzcv;
    logic [3:0]              out_alu_cond;
    logic                    out_ls_start;
    logic [FU_OP_SIZE-1:0]   out_ls_fu_op;
    logic [GPR_SIZE-1:0]     out_ls_val_a;
    logic [GPR_SIZE-1:0]     out_ls_val_b;
    logic [ROB_IDX_SIZE-1:0] out_ls_dst_rob_index;

    modport master (
        output in_disp_valid, in_disp_is_ls, in_disp_fu_op,
               in_disp_a_ready, in_disp_a_val, in_disp_a_tag,
               in_disp_b_ready, in_disp_b_val, in_disp_b_tag,
               in_disp_dst_rob_index, in_disp_set_nzcv, in_disp_nzcv, in_disp_cond,
               in_fu_done, in_fu_dst_rob_index, in_fu_value,
               in_fu_alu_ready, in_fu_ls_ready, in_flush,
        input  out_disp_ready,
               out_alu_start, out_alu_fu_op, out_alu_val_a, out_alu_val_b,
               out_alu_dst_rob_index, out_alu_set_nzcv, out_alu_nzcv, out_alu_cond,
               out_ls_start, out_ls_fu_op, out_ls_val_a, out_ls_val_b, out_ls_dst_rob_index
    );

    modport slave (
        input  in_disp_valid, in_disp_is_ls, in_disp_fu_op,
               in_disp_a_ready, in_disp_a_val, in_disp_a_tag,
               in_disp_b_ready, in_disp_b_val, in_disp_b_tag,
               in_disp_dst_rob_index, in_disp_set_nzcv, in_disp_nzcv, in_disp_cond,
               in_fu_done, in_fu_dst_rob_index, in_fu_value,
               in_fu_alu_ready, in_fu_ls_ready, in_flush,
        output out_disp_ready,
               out_alu_start, out_alu_fu_op, out_alu_val_a, out_alu_val_b,
               out_alu_dst_rob_index, out_alu_set_nzcv, out_alu_nzcv, out_alu_cond,
               out_ls_start, out_ls_fu_op, out_ls_val_a, out_ls_val_b, out_ls_dst_rob_index
    );
endinterface
`default_nettype wire

// File: rtl/rs_issue_queue.sv
`default_nettype none
// ============================================================================
// Module  : rs_issue_queue
// Brief   : Collapsing reservation station issuing one ready ALU/LS op per
//           cycle. Optional macro RS_WAKEUP_ISSUE_EN: issue on same-cycle wakeup.
// Rev     : 1.0
// ============================================================================
module rs_issue_queue #(
    parameter int RS_ENTRIES   = 8,
    parameter int GPR_SIZE     = 32,
    parameter int ROB_IDX_SIZE = 5,
    parameter int FU_OP_SIZE   = 4
) (
    input  wire logic       in_clk,
    input  wire logic       in_rst,
    rs_issue_queue_if.slave rs
);
    localparam int CNT_W = $clog2(RS_ENTRIES + 1);
    localparam int IDX_W = $clog2(RS_ENTRIES);

    typedef struct packed {
        logic                    valid;
        logic                    is_ls;
        logic [FU_OP_SIZE-1:0]   op;
        logic                    a_rdy;
        logic [GPR_SIZE-1:0]     a_val;
        logic [ROB_IDX_SIZE-1:0] a_tag;
        logic                    b_rdy;
        logic [GPR_SIZE-1:0]     b_val;
        logic [ROB_IDX_SIZE-1:0] b_tag;
        logic [ROB_IDX_SIZE-1:0] dst;
        logic                    set_nzcv;
        logic [3:0]              nzcv;
        logic [3:0]              cond;
    } entry_t;

    entry_t                  r_q [RS_ENTRIES];
    entry_t                  w_nq [RS_ENTRIES];
    entry_t                  w_disp_ent;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_count_nxt;
    logic [CNT_W-1:0]        w_disp_slot;
    logic [RS_ENTRIES-1:0]   w_a_ok;
    logic [RS_ENTRIES-1:0]   w_b_ok;
    logic [RS_ENTRIES-1:0]   w_elig;
    logic                    w_sel_found;
    logic [IDX_W-1:0]        w_sel_idx;
    logic                    w_ls_seen;
    logic                    w_issue;
    logic                    w_disp;
    logic                    w_disp_ready;
    logic                    w_sel_is_ls;
    logic [GPR_SIZE-1:0]     w_iss_a;
    logic [GPR_SIZE-1:0]     w_iss_b;

    logic                    r_alu_start;
    logic [FU_OP_SIZE-1:0]   r_alu_fu_op;
    logic [GPR_SIZE-1:0]     r_alu_val_a;
    logic [GPR_SIZE-1:0]     r_alu_val_b;
    logic [ROB_IDX_SIZE-1:0] r_alu_dst;
    logic                    r_alu_set_nzcv;
    logic [3:0]              r_alu_nzcv;
    logic [3:0]              r_alu_cond;
    logic                    r_ls_start;
    logic [FU_OP_SIZE-1:0]   r_ls_fu_op;
    logic [GPR_SIZE-1:0]     r_ls_val_a;
    logic [GPR_SIZE-1:0]     r_ls_val_b;
    logic [ROB_IDX_SIZE-1:0] r_ls_dst;

    // Operand readiness for eligibility; the macro lets a live broadcast count.
    always_comb begin
        w_a_ok = '0;
        w_b_ok = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
`ifdef RS_WAKEUP_ISSUE_EN
            w_a_ok[i] = r_q[i].a_rdy |
                        (rs.in_fu_done & (r_q[i].a_tag == rs.in_fu_dst_rob_index));
            w_b_ok[i] = r_q[i].b_rdy |
                        (rs.in_fu_done & (r_q[i].b_tag == rs.in_fu_dst_rob_index));
`else
            w_a_ok[i] = r_q[i].a_rdy;
            w_b_ok[i] = r_q[i].b_rdy;
`endif
        end
    end

    // Lowest eligible index wins; LS entries must also be the oldest LS entry.
    always_comb begin
        w_elig      = '0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_ls_seen   = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_elig[i] = r_q[i].valid & w_a_ok[i] & w_b_ok[i] &
                        (r_q[i].is_ls ? (rs.in_fu_ls_ready & ~w_ls_seen) : rs.in_fu_alu_ready);
            if (w_elig[i] && !w_sel_found) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
            if (r_q[i].valid && r_q[i].is_ls) begin
                w_ls_seen = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_is_ls = r_q[w_sel_idx].is_ls;
`ifdef RS_WAKEUP_ISSUE_EN
        w_iss_a = r_q[w_sel_idx].a_rdy ? r_q[w_sel_idx].a_val : rs.in_fu_value;
        w_iss_b = r_q[w_sel_idx].b_rdy ? r_q[w_sel_idx].b_val : rs.in_fu_value;
`else
        w_iss_a = r_q[w_sel_idx].a_val;
        w_iss_b = r_q[w_sel_idx].b_val;
`endif
    end

    assign w_disp_ready = (r_count < CNT_W'(RS_ENTRIES)) & ~in_rst;
    assign w_issue      = w_sel_found & ~rs.in_flush;
    assign w_disp       = rs.in_disp_valid & w_disp_ready;

    // Next queue image: compact, wake survivors, then append the dispatch.
    always_comb begin
        w_disp_slot = r_count - CNT_W'(w_issue);

        w_disp_ent          = '0;
        w_disp_ent.valid    = 1'b1;
        w_disp_ent.is_ls    = rs.in_disp_is_ls;
        w_disp_ent.op       = rs.in_disp_fu_op;
        w_disp_ent.a_rdy    = rs.in_disp_a_ready |
                              (rs.in_fu_done & (rs.in_disp_a_tag == rs.in_fu_dst_rob_index));
        w_disp_ent.a_val    = rs.in_disp_a_ready ? rs.in_disp_a_val : rs.in_fu_value;
        w_disp_ent.a_tag    = rs.in_disp_a_tag;
        w_disp_ent.b_rdy    = rs.in_disp_b_ready |
                              (rs.in_fu_done & (rs.in_disp_b_tag == rs.in_fu_dst_rob_index));
        w_disp_ent.b_val    = rs.in_disp_b_ready ? rs.in_disp_b_val : rs.in_fu_value;
        w_disp_ent.b_tag    = rs.in_disp_b_tag;
        w_disp_ent.dst      = rs.in_disp_dst_rob_index;
        w_disp_ent.set_nzcv = rs.in_disp_set_nzcv;
        w_disp_ent.nzcv     = rs.in_disp_nzcv;
        w_disp_ent.cond     = rs.in_disp_cond;

        for (int i = 0; i < RS_ENTRIES - 1; i++) begin
            w_nq[i] = (w_issue && (IDX_W'(i) >= w_sel_idx)) ? r_q[i + 1] : r_q[i];
        end
        w_nq[RS_ENTRIES-1] = w_issue ? '0 : r_q[RS_ENTRIES-1];

        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (rs.in_fu_done && w_nq[i].valid) begin
                if (!w_nq[i].a_rdy && (w_nq[i].a_tag == rs.in_fu_dst_rob_index)) begin
                    w_nq[i].a_rdy = 1'b1;
                    w_nq[i].a_val = rs.in_fu_value;
                end
                if (!w_nq[i].b_rdy && (w_nq[i].b_tag == rs.in_fu_dst_rob_index)) begin
                    w_nq[i].b_rdy = 1'b1;
                    w_nq[i].b_val = rs.in_fu_value;
                end
            end
            if (w_disp && (CNT_W'(i) == w_disp_slot)) begin
                w_nq[i] = w_disp_ent;
            end
        end

        w_count_nxt = r_count + CNT_W'(w_disp) - CNT_W'(w_issue);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_q[i] <= '0;
            end
            r_count        <= '0;
            r_alu_start    <= 1'b0;
            r_alu_fu_op    <= '0;
            r_alu_val_a    <= '0;
            r_alu_val_b    <= '0;
            r_alu_dst      <= '0;
            r_alu_set_nzcv <= 1'b0;
            r_alu_nzcv     <= '0;
            r_alu_cond     <= '0;
            r_ls_start     <= 1'b0;
            r_ls_fu_op     <= '0;
            r_ls_val_a     <= '0;
            r_ls_val_b     <= '0;
            r_ls_dst       <= '0;
        end else if (rs.in_flush) begin
            // Payload is left alone so an already-launched op keeps its operands.
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_q[i] <= '0;
            end
            r_count     <= '0;
            r_alu_start <= 1'b0;
            r_ls_start  <= 1'b0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_q[i] <= w_nq[i];
            end
            r_count     <= w_count_nxt;
            r_alu_start <= w_issue & ~w_sel_is_ls;
            r_ls_start  <= w_issue & w_sel_is_ls;
            if (w_issue && !w_sel_is_ls) begin
                r_alu_fu_op    <= r_q[w_sel_idx].op;
                r_alu_val_a    <= w_iss_a;
                r_alu_val_b    <= w_iss_b;
                r_alu_dst      <= r_q[w_sel_idx].dst;
                r_alu_set_nzcv <= r_q[w_sel_idx].set_nzcv;
                r_alu_nzcv     <= r_q[w_sel_idx].nzcv;
                r_alu_cond     <= r_q[w_sel_idx].cond;
            end
            if (w_issue && w_sel_is_ls) begin
                r_ls_fu_op <= r_q[w_sel_idx].op;
                r_ls_val_a <= w_iss_a;
                r_ls_val_b <= w_iss_b;
                r_ls_dst   <= r_q[w_sel_idx].dst;
            end
        end
    end

    assign rs.out_disp_ready        = w_disp_ready;
    assign rs.out_alu_start         = r_alu_start;
    assign rs.out_alu_fu_op         = r_alu_fu_op;
    assign rs.out_alu_val_a         = r_alu_val_a;
    assign rs.out_alu_val_b         = r_alu_val_b;
    assign rs.out_alu_dst_rob_index = r_alu_dst;
    assign rs.out_alu_set_nzcv      = r_alu_set_nzcv;
    assign rs.out_alu_nzcv          = r_alu_nzcv;
    assign rs.out_alu_cond          = r_alu_cond;
    assign rs.out_ls_start          = r_ls_start;
    assign rs.out_ls_fu_op          = r_ls_fu_op;
    assign rs.out_ls_val_a          = r_ls_val_a;
    assign rs.out_ls_val_b          = r_ls_val_b;
    assign rs.out_ls_dst_rob_index  = r_ls_dst;
endmodule
`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_rs_issue_queue
// Brief   : Directed scenarios plus randomized traffic against a queue-based
//           reference of the reservation station.
// Rev     : 1.0
// ============================================================================
module tb_rs_issue_queue;
    localparam int N   = 8;
    localparam int GPR = 32;
    localparam int ROB = 5;
    localparam int OPW = 4;
`ifdef RS_WAKEUP_ISSUE_EN
    localparam bit WAKE_ISSUE = 1'b1;
`else
    localparam bit WAKE_ISSUE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_issue_queue_if #(.GPR_SIZE(GPR), .ROB_IDX_SIZE(ROB), .FU_OP_SIZE(OPW)) rs ();

    rs_issue_queue #(
        .RS_ENTRIES(N), .GPR_SIZE(GPR), .ROB_IDX_SIZE(ROB), .FU_OP_SIZE(OPW)
    ) dut (
        .in_clk (clk),
        .in_rst (rst),
        .rs     (rs)
    );

    typedef struct {
        bit             is_ls;
        logic [OPW-1:0] op;
        bit             a_rdy;
        logic [GPR-1:0] a_val;
        logic [ROB-1:0] a_tag;
        bit             b_rdy;
        logic [GPR-1:0] b_val;
        logic [ROB-1:0] b_tag;
        logic [ROB-1:0] dst;
        logic           set_nzcv;
        logic [3:0]     nzcv;
        logic [3:0]     cond;
    } m_ent_t;

    m_ent_t         m_q[$];
    logic           e_alu_start, e_ls_start;
    logic [OPW-1:0] e_alu_op, e_ls_op;
    logic [GPR-1:0] e_alu_a, e_alu_b, e_ls_a, e_ls_b;
    logic [ROB-1:0] e_alu_dst, e_ls_dst;
    logic           e_alu_set;
    logic [3:0]     e_alu_nzcv, e_alu_cond;

    int checks   = 0;
    int failures = 0;

    function automatic bit hit(input logic [ROB-1:0] tag);
        return rs.in_fu_done && (tag == rs.in_fu_dst_rob_index);
    endfunction

    function automatic bit exp_ready();
        return (m_q.size() < N) && !rst;
    endfunction

    // Reference: ordered list of waiting ops, oldest first, advanced once per edge.
    task automatic model_step();
        int     sel;
        bit     ls_seen;
        bit     acc;
        m_ent_t e;
        sel     = -1;
        ls_seen = 1'b0;
        acc     = rs.in_disp_valid && exp_ready();
        for (int i = 0; i < m_q.size(); i++) begin
            bit a_ok, b_ok, fu_ok;
            a_ok  = m_q[i].a_rdy || (WAKE_ISSUE && hit(m_q[i].a_tag));
            b_ok  = m_q[i].b_rdy || (WAKE_ISSUE && hit(m_q[i].b_tag));
            fu_ok = m_q[i].is_ls ? (rs.in_fu_ls_ready && !ls_seen) : rs.in_fu_alu_ready;
            if (sel < 0 && a_ok && b_ok && fu_ok) sel = i;
            if (m_q[i].is_ls) ls_seen = 1'b1;
        end
        if (rst) begin
            m_q.delete();
            e_alu_start = 0; e_ls_start = 0;
            e_alu_op = '0; e_alu_a = '0; e_alu_b = '0; e_alu_dst = '0;
            e_alu_set = 0; e_alu_nzcv = '0; e_alu_cond = '0;
            e_ls_op = '0; e_ls_a = '0; e_ls_b = '0; e_ls_dst = '0;
        end else if (rs.in_flush) begin
            m_q.delete();
            e_alu_start = 0; e_ls_start = 0;
        end else begin
            e_alu_start = 0; e_ls_start = 0;
            if (sel >= 0) begin
                e = m_q[sel];
                if (e.is_ls) begin
                    e_ls_start = 1;
                    e_ls_op  = e.op;
                    e_ls_a   = e.a_rdy ? e.a_val : rs.in_fu_value;
                    e_ls_b   = e.b_rdy ? e.b_val : rs.in_fu_value;
                    e_ls_dst = e.dst;
                end else begin
                    e_alu_start = 1;
                    e_alu_op   = e.op;
                    e_alu_a    = e.a_rdy ? e.a_val : rs.in_fu_value;
                    e_alu_b    = e.b_rdy ? e.b_val : rs.in_fu_value;
                    e_alu_dst  = e.dst;
                    e_alu_set  = e.set_nzcv;
                    e_alu_nzcv = e.nzcv;
                    e_alu_cond = e.cond;
                end
                m_q.delete(sel);
            end
            for (int i = 0; i < m_q.size(); i++) begin
                e = m_q[i];
                if (!e.a_rdy && hit(e.a_tag)) begin e.a_rdy = 1; e.a_val = rs.in_fu_value; end
                if (!e.b_rdy && hit(e.b_tag)) begin e.b_rdy = 1; e.b_val = rs.in_fu_value; end
                m_q[i] = e;
            end
            if (acc) begin
                e.is_ls    = rs.in_disp_is_ls;
                e.op       = rs.in_disp_fu_op;
                e.a_rdy    = rs.in_disp_a_ready || hit(rs.in_disp_a_tag);
                e.a_val    = rs.in_disp_a_ready ? rs.in_disp_a_val : rs.in_fu_value;
                e.a_tag    = rs.in_disp_a_tag;
                e.b_rdy    = rs.in_disp_b_ready || hit(rs.in_disp_b_tag);
                e.b_val    = rs.in_disp_b_ready ? rs.in_disp_b_val : rs.in_fu_value;
                e.b_tag    = rs.in_disp_b_tag;
                e.dst      = rs.in_disp_dst_rob_index;
                e.set_nzcv = rs.in_disp_set_nzcv;
                e.nzcv     = rs.in_disp_nzcv;
                e.cond     = rs.in_disp_cond;
                m_q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rs.in_disp_valid = 0; rs.in_disp_is_ls = 0; rs.in_disp_fu_op = '0;
        rs.in_disp_a_ready = 0; rs.in_disp_a_val = '0; rs.in_disp_a_tag = '0;
        rs.in_disp_b_ready = 0; rs.in_disp_b_val = '0; rs.in_disp_b_tag = '0;
        rs.in_disp_dst_rob_index = '0; rs.in_disp_set_nzcv = 0;
        rs.in_disp_nzcv = '0; rs.in_disp_cond = '0;
        rs.in_fu_done = 0; rs.in_fu_dst_rob_index = '0; rs.in_fu_value = '0;
        rs.in_flush = 0;
    endtask

    task automatic set_disp(input bit is_ls, input logic [OPW-1:0] op,
                            input bit ar, input logic [GPR-1:0] av, input logic [ROB-1:0] at,
                            input bit br, input logic [GPR-1:0] bv, input logic [ROB-1:0] bt,
                            input logic [ROB-1:0] dst);
        rs.in_disp_valid = 1; rs.in_disp_is_ls = is_ls; rs.in_disp_fu_op = op;
        rs.in_disp_a_ready = ar; rs.in_disp_a_val = av; rs.in_disp_a_tag = at;
        rs.in_disp_b_ready = br; rs.in_disp_b_val = bv; rs.in_disp_b_tag = bt;
        rs.in_disp_dst_rob_index = dst;
        rs.in_disp_set_nzcv = 1'($urandom_range(0, 1));
        rs.in_disp_nzcv = 4'($urandom); rs.in_disp_cond = 4'($urandom);
    endtask

    task automatic do_flush();
        idle(); rs.in_flush = 1; tick(); rs.in_flush = 0;
    endtask

    task automatic test_reset();
        idle(); rs.in_fu_alu_ready = 0; rs.in_fu_ls_ready = 0;
        rst = 1; tick(); tick();
        checks++;
        if (rs.out_disp_ready !== 1'b0) begin
            failures++; $display("FAIL reset_disp_ready got=%b want=0", rs.out_disp_ready);
        end
        checks++;
        if ({rs.out_alu_start, rs.out_ls_start, rs.out_alu_val_a, rs.out_ls_dst_rob_index} !== '0) begin
            failures++; $display("FAIL reset_outputs got alu_start=%b ls_start=%b val_a=%h ls_dst=%h want all 0",
                rs.out_alu_start, rs.out_ls_start, rs.out_alu_val_a, rs.out_ls_dst_rob_index);
        end
        rst = 0; #1;
        checks++;
        if (rs.out_disp_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_disp_ready got=%b want=1", rs.out_disp_ready);
        end
    endtask

    task automatic test_alu_basic();
        rs.in_fu_alu_ready = 1; rs.in_fu_ls_ready = 1;
        set_disp(0, 4'd1, 1, 32'd5, '0, 1, 32'd7, '0, 5'd3);
        tick(); idle(); tick();
        checks++;
        if (rs.out_alu_start !== 1'b1 || rs.out_ls_start !== 1'b0 || rs.out_alu_val_a !== 32'd5 ||
            rs.out_alu_val_b !== 32'd7 || rs.out_alu_dst_rob_index !== 5'd3 || rs.out_alu_fu_op !== 4'd1) begin
            failures++; $display("FAIL alu_basic got start=%b a=%0d b=%0d dst=%0d op=%0d want 1 5 7 3 1",
                rs.out_alu_start, rs.out_alu_val_a, rs.out_alu_val_b, rs.out_alu_dst_rob_index, rs.out_alu_fu_op);
        end
        tick(); #1;
        checks++;
        if (rs.out_alu_start !== 1'b0 || rs.out_disp_ready !== 1'b1 || rs.out_alu_val_a !== 32'd5) begin
            failures++; $display("FAIL alu_basic_after got start=%b ready=%b a=%0d want 0 1 5",
                rs.out_alu_start, rs.out_disp_ready, rs.out_alu_val_a);
        end
    endtask

    task automatic test_wakeup();
        int lat;
        do_flush();
        rs.in_fu_alu_ready = 1; rs.in_fu_ls_ready = 1;
        set_disp(0, 4'd2, 0, '0, 5'd4, 1, 32'd1, '0, 5'd6);
        tick(); idle(); tick();
        checks++;
        if (rs.out_alu_start !== 1'b0) begin
            failures++; $display("FAIL wakeup_wait got start=%b want=0", rs.out_alu_start);
        end
        rs.in_fu_done = 1; rs.in_fu_dst_rob_index = 5'd4; rs.in_fu_value = 32'h10;
        tick(); idle();
        lat = 1;
        while (rs.out_alu_start !== 1'b1 && lat < 6) begin tick(); lat++; end
        checks++;
        if (lat != (WAKE_ISSUE ? 1 : 2) || rs.out_alu_val_a !== 32'h10 || rs.out_alu_dst_rob_index !== 5'd6) begin
            failures++; $display("FAIL wakeup_issue got lat=%0d a=%h dst=%0d want lat=%0d a=10 dst=6",
                lat, rs.out_alu_val_a, rs.out_alu_dst_rob_index, WAKE_ISSUE ? 1 : 2);
        end
    endtask

    task automatic test_full();
        int lat;
        do_flush();
        rs.in_fu_alu_ready = 1; rs.in_fu_ls_ready = 1;
        for (int i = 0; i < N; i++) begin
            set_disp(0, OPW'(i), 0, '0, ROB'(8 + i), 1, 32'd3, '0, ROB'(i));
            tick();
        end
        idle(); #1;
        checks++;
        if (rs.out_disp_ready !== 1'b0) begin
            failures++; $display("FAIL full_ready got=%b want=0", rs.out_disp_ready);
        end
        set_disp(0, 4'd9, 1, 32'd1, '0, 1, 32'd2, '0, 5'd31);
        tick(); idle(); tick();
        checks++;
        if (rs.out_alu_start !== 1'b0) begin
            failures++; $display("FAIL full_drop got start=%b want=0", rs.out_alu_start);
        end
        rs.in_fu_done = 1; rs.in_fu_dst_rob_index = 5'd10; rs.in_fu_value = 32'h22;
        tick(); idle();
        lat = 1;
        while (rs.out_alu_start !== 1'b1 && lat < 6) begin tick(); lat++; end
        #1;
        checks++;
        if (rs.out_alu_start !== 1'b1 || rs.out_alu_dst_rob_index !== 5'd2 ||
            rs.out_alu_val_a !== 32'h22 || rs.out_disp_ready !== 1'b1) begin
            failures++; $display("FAIL full_wake2 got start=%b dst=%0d a=%h ready=%b want 1 2 22 1",
                rs.out_alu_start, rs.out_alu_dst_rob_index, rs.out_alu_val_a, rs.out_disp_ready);
        end
        rs.in_fu_done = 1; rs.in_fu_dst_rob_index = 5'd11; rs.in_fu_value = 32'h33;
        tick(); idle();
        lat = 1;
        while (rs.out_alu_start !== 1'b1 && lat < 6) begin tick(); lat++; end
        checks++;
        if (rs.out_alu_start !== 1'b1 || rs.out_alu_dst_rob_index !== 5'd3 || rs.out_alu_val_a !== 32'h33) begin
            failures++; $display("FAIL full_shift got start=%b dst=%0d a=%h want 1 3 33",
                rs.out_alu_start, rs.out_alu_dst_rob_index, rs.out_alu_val_a);
        end
    endtask

    task automatic test_ls_order();
        logic [ROB-1:0] got[$];
        bit prev, consec;
        do_flush();
        rs.in_fu_alu_ready = 1; rs.in_fu_ls_ready = 1;
        set_disp(1, 4'd3, 0, '0, 5'd5, 1, 32'd4, '0, 5'd7);
        tick();
        set_disp(1, 4'd4, 1, 32'd9, '0, 1, 32'd2, '0, 5'd8);
        tick(); idle();
        prev = 0;
        for (int i = 0; i < 3; i++) begin tick(); prev = prev | rs.out_ls_start; end
        checks++;
        if (prev !== 1'b0) begin
            failures++; $display("FAIL ls_blocked got ls_start_seen=%b want=0", prev);
        end
        rs.in_fu_done = 1; rs.in_fu_dst_rob_index = 5'd5; rs.in_fu_value = 32'h55;
        tick(); idle();
        prev = 0; consec = 0;
        for (int i = 0; i < 10; i++) begin
            if (rs.out_ls_start === 1'b1) begin
                got.push_back(rs.out_ls_dst_rob_index);
                if (prev) consec = 1;
            end
            prev = (rs.out_ls_start === 1'b1);
            rs.in_fu_ls_ready = !prev;
            tick();
        end
        rs.in_fu_ls_ready = 1;
        checks++;
        if (got.size() != 2 || consec) begin
            failures++; $display("FAIL ls_order got issues=%0d consecutive=%b want 2 0", got.size(), consec);
        end else begin
            checks++;
            if (got[0] !== 5'd7 || got[1] !== 5'd8) begin
                failures++; $display("FAIL ls_order_dst got %0d,%0d want 7,8", got[0], got[1]);
            end
        end
    endtask

    task automatic test_ls_alu_priority();
        do_flush();
        rs.in_fu_alu_ready = 0; rs.in_fu_ls_ready = 0;
        set_disp(1, 4'd5, 1, 32'hA, '0, 1, 32'hB, '0, 5'd20);
        tick();
        set_disp(0, 4'd6, 1, 32'hC, '0, 1, 32'hD, '0, 5'd21);
        tick(); idle();
        rs.in_fu_alu_ready = 1; rs.in_fu_ls_ready = 1;
        tick();
        checks++;
        if (rs.out_ls_start !== 1'b1 || rs.out_alu_start !== 1'b0 || rs.out_ls_dst_rob_index !== 5'd20) begin
            failures++; $display("FAIL prio_first got ls=%b alu=%b ls_dst=%0d want 1 0 20",
                rs.out_ls_start, rs.out_alu_start, rs.out_ls_dst_rob_index);
        end
        tick();
        checks++;
        if (rs.out_alu_start !== 1'b1 || rs.out_ls_start !== 1'b0 || rs.out_alu_dst_rob_index !== 5'd21) begin
            failures++; $display("FAIL prio_second got alu=%b ls=%b alu_dst=%0d want 1 0 21",
                rs.out_alu_start, rs.out_ls_start, rs.out_alu_dst_rob_index);
        end
    endtask

    task automatic test_flush();
        bit seen;
        do_flush();
        rs.in_fu_alu_ready = 1; rs.in_fu_ls_ready = 1;
        for (int i = 0; i < 5; i++) begin
            set_disp(0, 4'd7, 0, '0, ROB'(24 + i), 1, 32'd1, '0, ROB'(24 + i));
            tick();
        end
        set_disp(0, 4'd8, 1, 32'd1, '0, 1, 32'd2, '0, 5'd30);
        rs.in_flush = 1;
        tick(); idle(); #1;
        checks++;
        if (rs.out_alu_start !== 1'b0 || rs.out_ls_start !== 1'b0 || rs.out_disp_ready !== 1'b1) begin
            failures++; $display("FAIL flush_state got alu=%b ls=%b ready=%b want 0 0 1",
                rs.out_alu_start, rs.out_ls_start, rs.out_disp_ready);
        end
        rs.in_fu_done = 1; rs.in_fu_dst_rob_index = 5'd24; rs.in_fu_value = 32'h77;
        tick(); idle();
        seen = 0;
        for (int i = 0; i < 3; i++) begin seen = seen | rs.out_alu_start | rs.out_ls_start; tick(); end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL flush_no_issue got start_seen=%b want=0", seen);
        end
    endtask

    task automatic test_random();
        do_flush();
        for (int c = 0; c < 800; c++) begin
            checks++;
            if ({rs.out_alu_start, rs.out_ls_start} !== {e_alu_start, e_ls_start}) begin
                failures++; $display("FAIL rand_starts cyc=%0d got alu=%b ls=%b want alu=%b ls=%b",
                    c, rs.out_alu_start, rs.out_ls_start, e_alu_start, e_ls_start);
            end
            checks++;
            if ({rs.out_alu_fu_op, rs.out_alu_val_a, rs.out_alu_val_b, rs.out_alu_dst_rob_index,
                 rs.out_alu_set_nzcv, rs.out_alu_nzcv, rs.out_alu_cond} !==
                {e_alu_op, e_alu_a, e_alu_b, e_alu_dst, e_alu_set, e_alu_nzcv, e_alu_cond}) begin
                failures++; $display("FAIL rand_alu_payload cyc=%0d got op=%h a=%h b=%h dst=%h want op=%h a=%h b=%h dst=%h",
                    c, rs.out_alu_fu_op, rs.out_alu_val_a, rs.out_alu_val_b, rs.out_alu_dst_rob_index,
                    e_alu_op, e_alu_a, e_alu_b, e_alu_dst);
            end
            checks++;
            if ({rs.out_ls_fu_op, rs.out_ls_val_a, rs.out_ls_val_b, rs.out_ls_dst_rob_index} !==
                {e_ls_op, e_ls_a, e_ls_b, e_ls_dst}) begin
                failures++; $display("FAIL rand_ls_payload cyc=%0d got op=%h a=%h b=%h dst=%h want op=%h a=%h b=%h dst=%h",
                    c, rs.out_ls_fu_op, rs.out_ls_val_a, rs.out_ls_val_b, rs.out_ls_dst_rob_index,
                    e_ls_op, e_ls_a, e_ls_b, e_ls_dst);
            end
            idle();
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 1) begin
                set_disp(1'($urandom_range(0, 9) < 4), OPW'($urandom),
                         1'($urandom_range(0, 1)), $urandom, ROB'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), $urandom, ROB'($urandom_range(0, 7)),
                         ROB'($urandom));
            end
            rs.in_fu_done          = ($urandom_range(0, 9) < 4);
            rs.in_fu_dst_rob_index = ROB'($urandom_range(0, 7));
            rs.in_fu_value         = $urandom;
            rs.in_fu_alu_ready     = ($urandom_range(0, 9) < 7);
            rs.in_fu_ls_ready      = ($urandom_range(0, 9) < 7);
            rs.in_flush            = ($urandom_range(0, 49) == 0);
            #1;
            checks++;
            if (rs.out_disp_ready !== exp_ready()) begin
                failures++; $display("FAIL rand_disp_ready cyc=%0d got=%b want=%b", c, rs.out_disp_ready, exp_ready());
            end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_basic();
        test_wakeup();
        test_full();
        test_ls_order();
        test_ls_alu_priority();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
